// File: rtl/pwm_audio_pkg.sv
// Shared constants for the PWM audio DAC: default widths and the silence level.
package pwm_audio_pkg;

  localparam int unsigned SAMPLE_WIDTH  = 8;
  localparam int unsigned SAMPLE_REPEAT = 4;

  // Unsigned PCM silence: half of full scale.
  function automatic int unsigned midscale(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/pwm_audio_dac.sv
// PCM-to-PWM audio DAC: one-entry sample buffer with valid/ready upstream,
// each sample held for REPEAT PWM frames of 2^WIDTH clocks.
module pwm_audio_dac
  import pwm_audio_pkg::*;
#(
  parameter int unsigned WIDTH  = SAMPLE_WIDTH,
  parameter int unsigned REPEAT = SAMPLE_REPEAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             sample_tick,
  output logic             underrun,
  output logic             pwm
);

  localparam int unsigned      REP_W   = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] MID     = WIDTH'(midscale(WIDTH));
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT - 1);

  logic [WIDTH-1:0] cnt, cnt_d;
  logic [REP_W-1:0] rep, rep_d;
  logic [WIDTH-1:0] cur, cur_d;
  logic [WIDTH-1:0] nxt, nxt_d;
  logic             nxt_full, nxt_full_d;
  logic             pwm_d, tick_d, underrun_d;
  logic             frame_end, load, accept;

  // Ready depends only on buffer state, never on sample_valid.
  assign sample_ready = ~nxt_full;
  assign frame_end    = (cnt == CNT_MAX);
  assign load         = frame_end && (rep == REP_MAX);
  assign accept       = sample_valid && ~nxt_full;

  // Next-state: frame/repeat counters, buffer handoff at the load event, PWM compare.
  always_comb begin
    cnt_d      = cnt + WIDTH'(1);
    rep_d      = rep;
    cur_d      = cur;
    nxt_d      = nxt;
    nxt_full_d = nxt_full;
    tick_d     = 1'b0;
    underrun_d = 1'b0;
    pwm_d      = (cnt < cur);

    if (frame_end) begin
      rep_d = (rep == REP_MAX) ? '0 : rep + REP_W'(1);
    end

    if (load) begin
      tick_d = 1'b1;
      if (nxt_full) begin
        cur_d      = nxt;
        nxt_full_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
      end
    end

    // An accept coinciding with an empty-buffer load lands in nxt only; it plays next period.
    if (accept) begin
      nxt_d      = sample_in;
      nxt_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      rep         <= '0;
      cur         <= MID;
      nxt         <= '0;
      nxt_full    <= 1'b0;
      pwm         <= 1'b0;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      cnt         <= cnt_d;
      rep         <= rep_d;
      cur         <= cur_d;
      nxt         <= nxt_d;
      nxt_full    <= nxt_full_d;
      pwm         <= pwm_d;
      sample_tick <= tick_d;
      underrun    <= underrun_d;
    end
  end

endmodule

// File: tb/tb_pwm_audio_dac.sv
// Self-checking bench for pwm_audio_dac: cycle model with a scoreboard queue of
// accepted samples, compared against the DUT outputs on every falling edge.
module tb_pwm_audio_dac;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned REPEAT = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] sample_in;
  logic             sample_valid;
  logic             sample_ready;
  logic             sample_tick;
  logic             underrun;
  logic             pwm;

  pwm_audio_dac #(.WIDTH(WIDTH), .REPEAT(REPEAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_tick  (sample_tick),
    .underrun     (underrun),
    .pwm          (pwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model state; values describe the current cycle after each rising edge.
  logic             running;
  logic [WIDTH-1:0] m_cnt;
  int               m_rep;
  logic [WIDTH-1:0] m_cur;
  logic             m_pwm, m_tick, m_under, m_acc, m_load;
  logic [WIDTH-1:0] sb[$];

  task automatic model_reset();
    m_cnt   = '0;
    m_rep   = 0;
    m_cur   = WIDTH'(1 << (WIDTH - 1));
    m_pwm   = 1'b0;
    m_tick  = 1'b0;
    m_under = 1'b0;
    m_acc   = 1'b0;
    sb.delete();
  endtask

  always @(posedge clk) begin
    if (running) begin
      m_load  = (m_cnt == WIDTH'((1 << WIDTH) - 1)) && (m_rep == REPEAT - 1);
      m_acc   = sample_valid && (sb.size() == 0);
      m_pwm   = (m_cnt < m_cur);
      m_tick  = m_load;
      m_under = 1'b0;
      if (m_load) begin
        if (sb.size() != 0) m_cur = sb.pop_front();
        else                m_under = 1'b1;
      end
      if (m_acc) sb.push_back(sample_in);
      if (m_cnt == WIDTH'((1 << WIDTH) - 1)) m_rep = (m_rep == REPEAT - 1) ? 0 : m_rep + 1;
      m_cnt = m_cnt + WIDTH'(1);
    end
  end

  always @(negedge clk) begin
    if (running && rst_n) begin
      check_eq("pwm", 32'(pwm), 32'(m_pwm));
      check_eq("sample_tick", 32'(sample_tick), 32'(m_tick));
      check_eq("underrun", 32'(underrun), 32'(m_under));
      check_eq("sample_ready", 32'(sample_ready), 32'(sb.size() == 0));
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one sample until the model's handshake takes it (bounded).
  task automatic push_sample(input logic [WIDTH-1:0] v);
    int guard;
    guard        = 0;
    sample_valid = 1'b1;
    sample_in    = v;
    do begin
      @(negedge clk);
      guard++;
    end while (!m_acc && guard < 3000);
    check_eq("push_accepted", 32'(m_acc), 32'd1);
    sample_valid = 1'b0;
  endtask

  initial begin
    int guard;
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    running      = 1'b0;
    model_reset();

    wait_cycles(3);
    check_eq("reset_pwm", 32'(pwm), 32'd0);
    check_eq("reset_tick", 32'(sample_tick), 32'd0);
    check_eq("reset_underrun", 32'(underrun), 32'd0);
    check_eq("reset_ready", 32'(sample_ready), 32'd1);
    rst_n   = 1'b1;
    running = 1'b1;

    // Idle: midscale output, underrun every sample period.
    wait_cycles(3 * 1024 + 100);

    // Continuous feed of 0x40: 64 high per frame, no underrun.
    sample_valid = 1'b1;
    sample_in    = 8'h40;
    wait_cycles(3 * 1024);
    sample_valid = 1'b0;

    // Extremes: constant low, then 255 high / 1 low.
    push_sample(8'h00);
    push_sample(8'hFF);
    wait_cycles(2 * 1024 + 50);

    // Backpressure with incrementing data held valid.
    sample_valid = 1'b1;
    sample_in    = 8'h80;
    repeat (4200) begin
      @(negedge clk);
      if (m_acc) sample_in = sample_in + 8'd1;
    end
    sample_valid = 1'b0;

    // Valid presented exactly on a load cycle with an empty buffer.
    guard = 0;
    while (!(sb.size() == 0 && m_cnt == 8'hFF && m_rep == REPEAT - 1) && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check_eq("collide_align", 32'(m_cnt), 32'hFF);
    sample_valid = 1'b1;
    sample_in    = 8'h33;
    @(negedge clk);
    sample_valid = 1'b0;
    check_eq("collide_underrun", 32'(underrun), 32'd1);
    check_eq("collide_tick", 32'(sample_tick), 32'd1);
    check_eq("collide_ready", 32'(sample_ready), 32'd0);
    wait_cycles(2 * 1024 + 50);

    // Reset mid-frame with a sample sitting in the buffer.
    push_sample(8'h99);
    guard = 0;
    while (m_cnt != 8'd20 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check_eq("pre_reset_pwm", 32'(pwm), 32'd1);
    check_eq("pre_reset_ready", 32'(sample_ready), 32'd0);
    running = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_pwm", 32'(pwm), 32'd0);
    check_eq("async_reset_tick", 32'(sample_tick), 32'd0);
    check_eq("async_reset_underrun", 32'(underrun), 32'd0);
    check_eq("async_reset_ready", 32'(sample_ready), 32'd1);
    model_reset();
    wait_cycles(5);
    rst_n   = 1'b1;
    running = 1'b1;
    @(negedge clk);
    check_eq("post_reset_ready", 32'(sample_ready), 32'd1);
    wait_cycles(2 * 1024 + 50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_audio_dac.md
Name: pwm_audio_dac

Overview:
- Converts a stream of unsigned PCM audio samples into a single-bit PWM output, one sample held for REPEAT PWM frames.
- Sits between the music/sample generator and the board pwm pin, in the PLL-generated 39.75 MHz domain.
- Upstream uses a valid/ready handshake into a one-entry buffer. A per-sample tick tells upstream when the next sample will be taken.
- At defaults the PWM frame rate is 39.75 MHz / 256 ≈ 155.3 kHz, and the sample rate ≈ 38.8 kHz.

Parameters:
- WIDTH, 8, sample and PWM counter width; PWM frame = 2^WIDTH clk cycles.
- REPEAT, 4, PWM frames per sample (>=1).

Ports:
- clk  input  1  system clock (39.75 MHz PLL output).
- rst_n  input  1  asynchronous active-low reset (e.g. PLL locked).
- sample_in  input  WIDTH  unsigned PCM sample.
- sample_valid  input  1  sample_in valid.
- sample_ready  output  1  buffer can accept a sample.
- sample_tick  output  1  one-cycle pulse when a new sample becomes active.
- underrun  output  1  one-cycle pulse when a sample period starts with an empty buffer.
- pwm  output  1  registered PWM output.

Behaviour:
- Reset (async assert, all state cleared immediately):
  - cnt=0, rep=0, cur=2^(WIDTH-1) (midscale, silence), nxt_full=0.
  - pwm=0, sample_tick=0, underrun=0.
  - Reset mid-frame discards both the buffered sample and the active sample.
- cnt: WIDTH-bit free-running counter, increments every clk, wraps 2^WIDTH-1 -> 0.
- rep: counts 0..REPEAT-1. Increments when cnt==2^WIDTH-1; wraps REPEAT-1 -> 0.
- load event = (cnt==2^WIDTH-1) && (rep==REPEAT-1).
- Buffer and handshake:
  - sample_ready = !nxt_full (combinational from register only; no combinational path from sample_valid).
  - Accept when sample_valid && sample_ready: nxt<=sample_in, nxt_full<=1.
- On load event:
  - If nxt_full: cur<=nxt, nxt_full<=0.
  - Else: cur holds its value and underrun pulses high for that following cycle.
  - sample_tick pulses for one cycle in either case, aligned with cur taking effect (cnt==0, rep==0).
- Simultaneous accept and load with nxt_full=0:
  - The accepted sample goes into nxt only; no bypass into cur.
  - underrun still fires.
  - The sample is used at the next load.
- With nxt_full=1, ready is 0, so no accept can collide with load. At the load cycle nxt_full clears; ready rises the next cycle.
- pwm <= (cnt < cur), registered, one cycle latency from cnt.
  - High for exactly cur cycles per frame.
  - cur=0 -> constant 0; cur=2^WIDTH-1 -> low 1 cycle per frame.
  - Full-on is not reachable by design.
- No arithmetic widening needed; the compare is unsigned at WIDTH bits.

Decomposition:
- Shared package pwm_audio_pkg:
  - default SAMPLE_WIDTH=8, REPEAT=4;
  - function/constant MIDSCALE = 2^(WIDTH-1).
- Single module; no sub-module needed.
- Expected size ~120-150 lines.

Test Plan:
- Reset, then hold rst_n=1 with no valid:
  - pwm high 128 of every 256 cycles (midscale);
  - sample_ready=1;
  - underrun and sample_tick pulse every 1024 cycles.
- Present 0x40 before the first load, then keep the buffer fed with 0x40:
  - pwm high exactly 64 consecutive cycles per 256, starting 1 cycle after cnt==0;
  - no underrun.
- Feed 0x00 then 0xFF:
  - 4 frames of constant 0;
  - then 4 frames of 255 high / 1 low;
  - sample_tick coincides with each change.
- Backpressure: hold sample_valid=1 continuously with incrementing data:
  - exactly one accept per 1024 cycles;
  - sample_ready low between accepts;
  - no sample lost or duplicated.
- Valid asserted exactly on a load cycle with empty buffer:
  - underrun pulses;
  - cur unchanged for that period;
  - the sample becomes active at the next load.
- Deassert rst_n mid-frame with nxt_full=1:
  - pwm drops to 0 immediately;
  - after release, midscale output and sample_ready=1;
  - the buffered sample is never output.
